pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator, successor to the single-output fixed-duty PWM. One shared period counter drives N_CH comparators, each with its own duty value. Period and duty values are programmable at run time through double-buffered shadow registers that take effect only at a period boundary, so the outputs never glitch. Used to drive LED dimming and motor-drive channels from a control FSM.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_multi_if.sv | 15 +
 rtl/pwm_cmp_ch.sv | 51 +++++
 rtl/pwm_multi.sv | 126 ++++++++++++
 tb/tb_pwm_multi.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block.
package pwm_pkg;

   localparam int PWM_CNT_W = 8;

   typedef logic [PWM_CNT_W-1:0] cnt_t;

   typedef enum logic {
      PWM_UP     = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   localparam cnt_t PWM_DUTY_OFF = '0;

endpackage

// File: rtl/pwm_multi_if.sv
// Programming bus of pwm_multi: a load strobe with period/duty values and the pending flag.
interface pwm_multi_if #(
   parameter int CNT_W = 8,
   parameter int N_CH  = 4
);

   logic                  load_i;
   logic [CNT_W-1:0]      period_i;
   logic [N_CH*CNT_W-1:0] duty_i;
   logic                  pend_o;

   modport master (output load_i, output period_i, output duty_i, input  pend_o);
   modport slave  (input  load_i, input  period_i, input  duty_i, output pend_o);

endinterface

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: double-buffered duty register and a registered comparator against the shared counter.
module pwm_cmp_ch
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             bypass_i,
   input  logic             stage_i,
   input  logic             apply_i,
   input  logic [CNT_W-1:0] duty_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             dout_o
);

   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
   logic             dout_q, dout_d;

   // The comparison uses next-state count and duty so the registered output lines up with cnt.
   always_comb begin
      duty_act_d  = duty_act_q;
      duty_pend_d = duty_pend_q;
      if (bypass_i) begin
         duty_act_d = duty_i;
      end else if (apply_i) begin
         duty_act_d = duty_pend_q;
      end
      if (stage_i) begin
         duty_pend_d = duty_i;
      end
      dout_d = run_i && (cnt_i < duty_act_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_act_q  <= CNT_W'(PWM_DUTY_OFF);
         duty_pend_q <= CNT_W'(PWM_DUTY_OFF);
         dout_q      <= 1'b0;
      end else begin
         duty_act_q  <= duty_act_d;
         duty_pend_q <= duty_pend_d;
         dout_q      <= dout_d;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter and glitch-free shadow updates at period boundaries.
// Optional up/down (centre-aligned) counting is built when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int N_CH  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic            center_i,
`endif
   pwm_multi_if.slave      cfg,
   output logic [N_CH-1:0] dout,
   output logic            period_end_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_act_q, period_act_d;
   logic [CNT_W-1:0] period_pend_q, period_pend_d;
   logic             pend_q, pend_d;
   logic             period_end_q;
   logic             wrap, bypass, stage, apply_pend;

`ifdef PWM_CENTER_ALIGN_EN
   pwm_mode_e mode_q, mode_d;
   logic      dir_down_q, dir_down_d;

   // Centre mode walks 0..P..1 and turns around at P; the boundary is the step back to 0.
   always_comb begin
      cnt_d      = '0;
      dir_down_d = 1'b0;
      mode_d     = mode_q;
      if (en_i && mode_q == PWM_CENTER) begin
         if (period_act_q == '0) begin
            cnt_d = '0;
         end else if (!dir_down_q && cnt_q != period_act_q) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
         dir_down_d = (cnt_d != '0) && (dir_down_q || cnt_q == period_act_q);
      end else if (en_i) begin
         cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + CNT_W'(1);
      end
      if (wrap || !en_i) begin
         mode_d = center_i ? PWM_CENTER : PWM_UP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= PWM_UP;
         dir_down_q <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         dir_down_q <= dir_down_d;
      end
   end
`else
   always_comb begin
      cnt_d = '0;
      if (en_i) begin
         cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + CNT_W'(1);
      end
   end
`endif

   // A load on the wrap edge goes straight to the active set; idle time commits pending values.
   always_comb begin
      wrap          = en_i && (cnt_d == '0);
      bypass        = cfg.load_i && wrap;
      stage         = cfg.load_i && !wrap;
      apply_pend    = !cfg.load_i && pend_q && (wrap || !en_i);
      period_act_d  = period_act_q;
      period_pend_d = period_pend_q;
      pend_d        = pend_q;
      if (bypass) begin
         period_act_d = cfg.period_i;
      end else if (apply_pend) begin
         period_act_d = period_pend_q;
      end
      if (stage) begin
         period_pend_d = cfg.period_i;
         pend_d        = 1'b1;
      end else if (wrap || !en_i) begin
         pend_d        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         period_act_q  <= '0;
         period_pend_q <= '0;
         pend_q        <= 1'b0;
         period_end_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         period_act_q  <= period_act_d;
         period_pend_q <= period_pend_d;
         pend_q        <= pend_d;
         period_end_q  <= wrap;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      pwm_cmp_ch #(.CNT_W(CNT_W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .run_i    (en_i),
         .bypass_i (bypass),
         .stage_i  (stage),
         .apply_i  (apply_pend),
         .duty_i   (cfg.duty_i[k*CNT_W +: CNT_W]),
         .cnt_i    (cnt_d),
         .dout_o   (dout[k])
      );
   end

   assign period_end_o = period_end_q;
   assign cfg.pend_o   = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi (CNT_W=4, N_CH=2): stimulus pushes hand-derived expectations, a monitor checks them.
module tb_pwm_multi;

   bit         clk;
   logic       rst;
   logic       en;
   logic [1:0] dout;
   logic       periodEnd;
`ifdef PWM_CENTER_ALIGN_EN
   logic       center;
   int         seq [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
`endif

   typedef struct {
      string      name;
      logic [1:0] dout;
      logic       pe;
      logic       pend;
   } exp_t;

   exp_t expQ [$];
   int   testsRun;
   int   failCount;
   int   pos;

   pwm_multi_if #(.CNT_W(4), .N_CH(2)) cfg ();

   pwm_multi #(.CNT_W(4), .N_CH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en),
`ifdef PWM_CENTER_ALIGN_EN
      .center_i     (center),
`endif
      .cfg          (cfg),
      .dout         (dout),
      .period_end_o (periodEnd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input exp_t e);
      testsRun++;
      if (dout !== e.dout) begin
         failCount++;
         $display("[TB] FAIL %s.dout actual=%b required=%b", e.name, dout, e.dout);
      end
      testsRun++;
      if (periodEnd !== e.pe) begin
         failCount++;
         $display("[TB] FAIL %s.period_end actual=%b required=%b", e.name, periodEnd, e.pe);
      end
      testsRun++;
      if (cfg.pend_o !== e.pend) begin
         failCount++;
         $display("[TB] FAIL %s.pend actual=%b required=%b", e.name, cfg.pend_o, e.pend);
      end
   endtask

   // Monitor: every output cycle is compared against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic applyStimulus(input string nm, input bit r, input bit e, input bit ld,
                                input int p, input int d0, input int d1,
                                input logic [1:0] eDout, input bit ePe, input bit ePend);
      exp_t x;
      rst        = r;
      en         = e;
      cfg.load_i = ld;
      if (ld) begin
         cfg.period_i = 4'(p);
         cfg.duty_i   = {4'(d1), 4'(d0)};
      end
      x.name = nm;
      x.dout = eDout;
      x.pe   = ePe;
      x.pend = ePend;
      expQ.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic runN(input string nm, input int n, input int p, input int d0, input int d1,
                       input bit ePend);
      for (int i = 0; i < n; i++) begin
         pos = (pos == p) ? 0 : pos + 1;
         applyStimulus(nm, 0, 1, 0, 0, 0, 0, {pos < d1, pos < d0}, pos == 0, ePend);
      end
   endtask

   initial begin
      testsRun     = 0;
      failCount    = 0;
      pos          = 0;
      rst          = 1'b1;
      en           = 1'b0;
      cfg.load_i   = 1'b0;
      cfg.period_i = '0;
      cfg.duty_i   = '0;
`ifdef PWM_CENTER_ALIGN_EN
      center       = 1'b0;
`endif
      applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      applyStimulus("reset1", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);

      applyStimulus("idleLoad", 0, 0, 1, 9, 3, 7, 2'b00, 0, 1);
      applyStimulus("idleApply", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      runN("basic", 39, 9, 3, 7, 0);

      applyStimulus("wrapLoadEdge", 0, 1, 1, 9, 0, 10, 2'b10, 1, 0);
      pos = 0;
      runN("dutyEdge", 23, 9, 0, 10, 0);
      applyStimulus("stageP15", 0, 1, 1, 15, 15, 15, 2'b10, 0, 1);
      pos = 4;
      runN("pendHold", 5, 9, 0, 10, 1);
      applyStimulus("applyP15", 0, 1, 0, 0, 0, 0, 2'b11, 1, 0);
      pos = 0;
      runN("p15", 36, 15, 15, 15, 0);

      applyStimulus("midReload", 0, 1, 1, 9, 5, 5, 2'b11, 0, 1);
      pos = 5;
      runN("oldDuty", 10, 15, 15, 15, 1);
      applyStimulus("reloadWrap", 0, 1, 0, 0, 0, 0, 2'b11, 1, 0);
      pos = 0;
      runN("dutyFive", 13, 9, 5, 5, 0);

      applyStimulus("firstLoad", 0, 1, 1, 9, 1, 1, 2'b11, 0, 1);
      applyStimulus("secondLoad", 0, 1, 1, 9, 6, 8, 2'b00, 0, 1);
      pos = 5;
      runN("twoLoadHold", 4, 9, 5, 5, 1);
      applyStimulus("lastWins", 0, 1, 0, 0, 0, 0, 2'b11, 1, 0);
      pos = 0;
      runN("lastWinsRun", 19, 9, 6, 8, 0);
      applyStimulus("bypass", 0, 1, 1, 9, 2, 2, 2'b11, 1, 0);
      pos = 0;
      runN("bypassRun", 16, 9, 2, 2, 0);

      applyStimulus("disable", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      pos = 0;
      applyStimulus("idleLoad2", 0, 0, 1, 9, 4, 1, 2'b00, 0, 1);
      applyStimulus("idleApply2", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      runN("reenable", 24, 9, 4, 1, 0);

      applyStimulus("loadBeforeRst", 0, 1, 1, 9, 3, 3, 2'b00, 0, 1);
      applyStimulus("resetMid", 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      pos = 0;
      runN("afterRst", 5, 0, 0, 0, 0);
      applyStimulus("p0Load", 0, 1, 1, 0, 1, 0, 2'b01, 1, 0);
      runN("p0", 4, 0, 1, 0, 0);

`ifdef PWM_CENTER_ALIGN_EN
      center = 1'b1;
      applyStimulus("ctrLoad", 0, 1, 1, 4, 2, 2, 2'b11, 1, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus("center", 0, 1, 0, 0, 0, 0, {2{seq[i % 8] < 2}}, seq[i % 8] == 0, 0);
      end
`endif

      @(negedge clk);
      #1;
      testsRun++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain queued=%0d required=0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
